// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory port,
// hosts the boot loader path, and fills the IF/ID pipeline register.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle pulse, BOOT -> RUN
//   load_we/addr/data loader write port, honoured only in BOOT
//   stall             hold PC and IF/ID
//   redirect(_pc)     taken branch/jump; replaces the PC, squashes IF/ID
//   im_wea/addr/din   memory write enable, address, write data
//   im_dout           memory read data (registered-address, 1-cycle latency)
//   if_id_*           IF/ID pipeline register contents
//   running           high in RUN
module instruction_fetch #(
    parameter int          IMSIZE   = 8,
    parameter int          RESET_PC = 0,
    parameter logic [31:0] NOP_WORD = 32'h00000020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_we,
    input  logic [IMSIZE-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [IMSIZE-1:0] redirect_pc,
    output logic              im_wea,
    output logic [IMSIZE-1:0] im_addr,
    output logic [31:0]       im_din,
    input  logic [31:0]       im_dout,
    output logic [31:0]       if_id_instr,
    output logic [IMSIZE-1:0] if_id_pc,
    output logic [IMSIZE-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              running
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [IMSIZE-1:0] LP_RESET_PC = IMSIZE'(RESET_PC);

    state_t            r_state;
    logic [IMSIZE-1:0] r_pc;
    logic              r_pc_valid;
    logic [31:0]       r_instr;
    logic [IMSIZE-1:0] r_if_pc;
    logic [IMSIZE-1:0] r_if_pc1;
    logic              r_if_valid;
    logic              r_running;

    logic              w_boot;
    logic [IMSIZE-1:0] w_pc_plus1;
    logic [IMSIZE-1:0] w_next_pc;

    assign w_boot     = (r_state == S_BOOT);
    assign w_pc_plus1 = r_pc + 1'b1;

    // Redirect beats stall; otherwise advance with natural wrap.
    always_comb begin
        w_next_pc = w_pc_plus1;
        if (redirect) begin
            w_next_pc = redirect_pc;
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    // In BOOT the loader owns the port, except on the start cycle where
    // the first fetch address is presented and any write is dropped.
    always_comb begin
        im_addr = w_next_pc;
        if (w_boot) begin
            im_addr = start ? LP_RESET_PC : load_addr;
        end
    end

    assign im_wea = w_boot & load_we & ~start;
    assign im_din = load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= LP_RESET_PC;
            r_pc_valid <= 1'b0;
            r_instr    <= NOP_WORD;
            r_if_pc    <= '0;
            r_if_pc1   <= '0;
            r_if_valid <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            unique case (r_state)
                S_BOOT: begin
                    r_instr    <= NOP_WORD;
                    r_if_valid <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_pc       <= LP_RESET_PC;
                        r_pc_valid <= 1'b1;
                        r_running  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_pc <= w_next_pc;
                    // im_dout holds mem[r_pc]; a redirect squashes it.
                    if (redirect) begin
                        r_instr    <= NOP_WORD;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr    <= im_dout;
                        r_if_pc    <= r_pc;
                        r_if_pc1   <= w_pc_plus1;
                        r_if_valid <= r_pc_valid;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_plus1 = r_if_pc1;
    assign if_id_valid    = r_if_valid;
    assign running        = r_running;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory: owns the PC and drives the memory address.
- Accounts for the memory's one-cycle registered-address read latency and captures the returned word into the IF/ID pipeline register.
- Has a BOOT mode in which an external loader writes program words into the memory through this block.
- Leaves BOOT on a start pulse and then fetches sequentially, with stall and branch/jump redirect support.

Parameters:
IMSIZE  8  PC / memory address width; the PC is a word index (target 50 means word 50).
RESET_PC  0  Word address of the first fetched instruction.
NOP_WORD  32'h00000020  Bubble encoding (add $0,$0,$0).

Ports:
clk  in  1  System clock, rising edge.
rst  in  1  Synchronous, active-high reset.
start  in  1  One-cycle pulse; BOOT->RUN.
load_we  in  1  Loader write strobe (BOOT only).
load_addr  in  IMSIZE  Loader word address.
load_data  in  32  Loader instruction word.
stall  in  1  Hold PC and IF/ID (hazard from decode).
redirect  in  1  Taken branch/jump/jr; replace PC.
redirect_pc  in  IMSIZE  Redirect target word address.
im_wea  out  1  Memory write enable.
im_addr  out  IMSIZE  Memory address; the memory samples it at the clock edge.
im_din  out  32  Memory write data.
im_dout  in  32  Memory read data; holds the word at the address sampled at the previous edge.
if_id_instr  out  32  Registered instruction to decode.
if_id_pc  out  IMSIZE  Word address of if_id_instr.
if_id_pc_plus1  out  IMSIZE  if_id_pc+1 mod 2^IMSIZE (jal link / branch base).
if_id_valid  out  1  1 = real instruction, 0 = bubble.
running  out  1  1 in RUN state.

Behaviour:
- State machine: BOOT, RUN.
  - rst (any state, any cycle) -> BOOT.
  - BOOT & start -> RUN.
  - RUN remains in RUN until rst.
- Reset values (registered): pc=RESET_PC, pc_valid=0, if_id_instr=NOP_WORD, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, running=0.
- BOOT:
  - im_addr=load_addr, im_din=load_data, im_wea=load_we & ~start.
  - IF/ID holds bubble; stall and redirect are ignored.
- start cycle (BOOT & start):
  - im_addr=RESET_PC, im_wea=0; a write presented in the same cycle is dropped.
  - Next edge: pc<=RESET_PC, pc_valid<=1, running<=1.
- RUN next-PC priority (combinational, drives im_addr):
  1. redirect -> redirect_pc.
  2. stall -> pc.
  3. otherwise pc+1, wrapping 2^IMSIZE-1 -> 0.
- RUN clocking:
  - pc<=next_pc every cycle.
  - im_wea=0, im_din=load_data; load_we is ignored.
- Latency and invariant: im_dout always equals mem[pc] when pc_valid=1. Instruction at address A reaches if_id_instr 2 edges after A is driven on im_addr.
- IF/ID update rules:
  - redirect=1: if_id_instr<=NOP_WORD, if_id_valid<=0, if_id_pc/pc_plus1 hold. This squashes the wrong-path word.
  - redirect=0, stall=1: all IF/ID registers hold.
  - Otherwise: if_id_instr<=im_dout, if_id_pc<=pc, if_id_pc_plus1<=pc+1, if_id_valid<=pc_valid.
- Simultaneous redirect & stall: redirect wins; the PC takes the target and IF/ID takes a bubble.
- Redirect to the current pc (self-loop): legal, refetches.
- Reset mid-RUN: the next edge gives reset values and im_addr=load_addr. There is no partial IF/ID update.
- Back-to-back redirects on consecutive cycles: each one squashes; only the last target proceeds.

Test Plan:
- Boot load: rst, then load_we words 0x11..0x14 at addresses 0..3, then start. Required: im_wea high for exactly 4 cycles; if_id_instr = 0x11, 0x12, 0x13, 0x14 on consecutive cycles starting 2 cycles after start, with if_id_pc = 0..3 and if_id_valid=1.
- Stall: at if_id_pc=2, assert stall for 3 cycles. Required: if_id_instr/pc frozen at 2 for the duration, im_addr constant at 3; after release, the sequence resumes at 3 with no skip or duplicate.
- Redirect: in RUN with pc=15, assert redirect with redirect_pc=34. Required:
  - next im_addr=34 and next IF/ID is a bubble (NOP_WORD, valid=0);
  - if_id_pc=34 two cycles later, and 16 never appears valid.
- Redirect+stall same cycle (target 7): the redirect takes effect exactly as in the redirect case above.
- Wrap: redirect to 254 and run. Required: if_id_pc sequence 254, 255, 0 with if_id_pc_plus1 = 255, 0, 1.
- Reset in RUN, plus load/start conflict:
  - rst at if_id_pc=40 -> next cycle all outputs at reset values, running=0, and load writes accepted again.
  - load_we together with start -> im_wea=0 and memory unchanged.
